// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide,
// with sign handling and divide special cases resolved when the request is accepted.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    state_t      state_r;
    state_t      state_nx_s;
    logic [2:0]  op_r;
    logic [31:0] a_mag_r;
    logic [31:0] b_mag_r;
    logic [63:0] prod_r;
    logic [4:0]  cnt_r;
    logic        neg_q_r;
    logic        neg_rem_r;
    logic        special_r;
    logic [31:0] result_r;
    logic        busy_r;
    logic        done_r;

    logic        accept_s;
    logic        is_div_s;
    logic        a_signed_s;
    logic        b_signed_s;
    logic        sa_s;
    logic        sb_s;
    logic [31:0] a_abs_s;
    logic [31:0] b_abs_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        special_s;
    logic [31:0] spec_val_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_step_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_step_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;
    logic [31:0] fix_val_s;

    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

    // Operand decode at accept: signedness, magnitudes and divide special cases
    always_comb begin
        is_div_s   = funct3[2];
        a_signed_s = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                     (funct3 == OP_DIV) || (funct3 == OP_REM);
        b_signed_s = (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
                     (funct3 == OP_DIV) || (funct3 == OP_REM);
        sa_s       = a_signed_s && rs1_data[31];
        sb_s       = b_signed_s && rs2_data[31];
        a_abs_s    = sa_s ? (32'd0 - rs1_data) : rs1_data;
        b_abs_s    = sb_s ? (32'd0 - rs2_data) : rs2_data;
        div_zero_s = is_div_s && (rs2_data == 32'd0);
        div_ovf_s  = is_div_s && !funct3[0] &&
                     (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
        special_s  = div_zero_s || div_ovf_s;
        if (div_zero_s) begin
            spec_val_s = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        end else if (div_ovf_s) begin
            spec_val_s = funct3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            spec_val_s = 32'd0;
        end
    end

    // One iteration of multiply (right-shifting product) and restoring divide
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, a_mag_r} : 33'd0);
        mul_step_s  = {mul_sum_s, prod_r[31:1]};
        div_shift_s = {prod_r[63:32], prod_r[31]};
        div_diff_s  = div_shift_s - {1'b0, b_mag_r};
        if (!div_diff_s[32]) begin
            div_step_s = {div_diff_s[31:0], prod_r[30:0], 1'b1};
        end else begin
            div_step_s = {div_shift_s[31:0], prod_r[30:0], 1'b0};
        end
    end

    // Sign correction and output selection for the FIX state
    always_comb begin
        prod_fix_s = neg_q_r ? (64'd0 - prod_r) : prod_r;
        quo_fix_s  = neg_q_r ? (32'd0 - prod_r[31:0]) : prod_r[31:0];
        rem_fix_s  = neg_rem_r ? (32'd0 - prod_r[63:32]) : prod_r[63:32];
        if (special_r) begin
            fix_val_s = prod_r[31:0];
        end else begin
            case (op_r)
                3'b000:                 fix_val_s = prod_fix_s[31:0];
                3'b001, 3'b010, 3'b011: fix_val_s = prod_fix_s[63:32];
                3'b100, 3'b101:         fix_val_s = quo_fix_s;
                3'b110, 3'b111:         fix_val_s = rem_fix_s;
                default:                fix_val_s = 32'd0;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nx_s = special_s ? FIX : CALC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 5'd31) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = CALC;
                end
            end
            FIX:     state_nx_s = DONE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register with status flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == CALC) || (state_nx_s == FIX);
            done_r  <= (state_nx_s == DONE);
        end
    end

    // Datapath: load at accept, iterate in CALC, capture result in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 3'd0;
            a_mag_r   <= 32'd0;
            b_mag_r   <= 32'd0;
            prod_r    <= 64'd0;
            cnt_r     <= 5'd0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            special_r <= 1'b0;
            result_r  <= 32'd0;
        end else if (accept_s) begin
            op_r      <= funct3;
            a_mag_r   <= a_abs_s;
            b_mag_r   <= b_abs_s;
            cnt_r     <= 5'd0;
            neg_q_r   <= sa_s ^ sb_s;
            neg_rem_r <= sa_s;
            special_r <= special_s;
            if (special_s) begin
                prod_r <= {32'd0, spec_val_s};
            end else if (is_div_s) begin
                prod_r <= {32'd0, a_abs_s};
            end else begin
                prod_r <= {32'd0, b_abs_s};
            end
        end else if (state_r == CALC) begin
            prod_r <= op_r[2] ? div_step_s : mul_step_s;
            cnt_r  <= cnt_r + 5'd1;
        end else if (state_r == FIX) begin
            result_r <= fix_val_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus random ops against an
// arithmetic reference model, checking latency, busy, result hold and reset behaviour.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_result = 32'd0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] up;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        logic special;
        special = f[2] && ((b == 32'd0) ||
                  (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        return special ? 2 : 34;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; issues the op, follows it to done and checks it there.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at);
        logic [31:0] exp_res;
        int          exp_lat;
        int          cyc;
        exp_res  = ref_result(f, a, b);
        exp_lat  = ref_latency(f, a, b);
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        @(posedge clk);
        @(negedge clk);
        rs1_data = $urandom;
        rs2_data = $urandom;
        funct3   = 3'($urandom);
        cyc      = 1;
        while (cyc < 60) begin
            start = 1'b0;
            if (done) break;
            check("busy_during_op", {31'd0, busy}, 32'd1);
            check("result_hold", result, prev_result);
            if (cyc == pulse_at) begin
                start    = 1'b1;
                funct3   = 3'($urandom);
                rs1_data = $urandom;
                rs2_data = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("result", result, exp_res);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (done === 1'b1) prev_result = exp_res;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done", {31'd0, done}, 32'd0);
            check("idle_result_hold", result, prev_result);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        funct3   = 3'd0;
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 10);
        idle_cycles(1);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd5, 32'd100, 32'd7, 0);
        do_op(3'd7, 32'd100, 32'd7, 0);
        idle_cycles(2);
        do_op(3'd5, 32'd100, 32'd0, 0);
        do_op(3'd6, 32'd100, 32'd0, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle_cycles(1);
        do_op(3'd0, 32'd3, 32'd5, 0);
        do_op(3'd0, 32'd6, 32'd6, 0);
        idle_cycles(3);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            f = 3'($urandom);
            do_op(f, rand_operand(), rand_operand(), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end

        start    = 1'b1;
        funct3   = 3'd4;
        rs1_data = 32'hFFFF_FFF9;
        rs2_data = 32'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", {31'd0, busy}, 32'd0);
        check("midop_reset_done", {31'd0, done}, 32'd0);
        check("midop_reset_result", result, 32'd0);
        prev_result = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
        do_op(3'd5, 32'd9, 32'd3, 0);
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
